// File: rtl/ipv4_header_extractor.sv
// Pulls src/dst address, protocol and total length out of a word-aligned IPv4 stream.
// Result registered one cycle after header word 4; only the dst-capture word stalls while a result is pending.
module ipv4_header_extractor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      out_src_ip,
  output logic [31:0]      out_dst_ip,
  output logic [7:0]       out_protocol,
  output logic [15:0]      out_total_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {W0, HDR, SKIP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [2:0]  idx;
  logic [15:0] len_q;
  logic [7:0]  proto_q;
  logic [31:0] src_q;

  logic accept;
  logic hdr_ok;
  logic capture;

  assign in_ready = !(out_valid && state == HDR && idx == 3'd4 && !out_ready);
  assign accept   = in_valid && in_ready;
  assign hdr_ok   = (in_data[31:28] == 4'd4) && (in_data[27:24] >= 4'd5);
  assign capture  = accept && state == HDR && idx == 3'd4;

  // Fields are staged privately so the output registers move only on a full capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= W0;
      idx           <= 3'd0;
      len_q         <= '0;
      proto_q       <= '0;
      src_q         <= '0;
      out_src_ip    <= '0;
      out_dst_ip    <= '0;
      out_protocol  <= '0;
      out_total_len <= '0;
      out_valid     <= 1'b0;
      pkt_count     <= '0;
      err_count     <= '0;
    end else begin
      if (capture) begin
        out_valid     <= 1'b1;
        out_src_ip    <= src_q;
        out_dst_ip    <= in_data;
        out_protocol  <= proto_q;
        out_total_len <= len_q;
        if (pkt_count != CNT_MAX) pkt_count <= pkt_count + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        case (state)
          W0: begin
            if (hdr_ok && !in_last) begin
              len_q <= in_data[15:0];
              state <= HDR;
              idx   <= 3'd1;
            end else begin
              if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
              state <= (hdr_ok || in_last) ? W0 : SKIP;
              idx   <= 3'd0;
            end
          end
          HDR: begin
            if (idx == 3'd2) proto_q <= in_data[23:16];
            if (idx == 3'd3) src_q   <= in_data;
            if (idx == 3'd4) begin
              state <= in_last ? W0 : SKIP;
              idx   <= 3'd0;
            end else if (in_last) begin
              if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
              state <= W0;
              idx   <= 3'd0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          SKIP: begin
            if (in_last) state <= W0;
          end
          default: begin
            state <= W0;
            idx   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipv4_header_extractor.sv
// Directed bench for ipv4_header_extractor; a second CNT_W=2 instance covers counter saturation.
module tb_ipv4_header_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid;
  logic [31:0] out_src_ip, out_dst_ip;
  logic [7:0]  out_protocol;
  logic [15:0] out_total_len;
  logic [15:0] pkt_count, err_count;

  logic        in_ready2, out_valid2;
  logic [31:0] out_src_ip2, out_dst_ip2;
  logic [7:0]  out_protocol2;
  logic [15:0] out_total_len2;
  logic [1:0]  pkt_count2, err_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ipv4_header_extractor #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_src_ip(out_src_ip), .out_dst_ip(out_dst_ip),
    .out_protocol(out_protocol), .out_total_len(out_total_len), .out_valid(out_valid),
    .out_ready(out_ready), .pkt_count(pkt_count), .err_count(err_count)
  );

  ipv4_header_extractor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst2), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready2), .out_src_ip(out_src_ip2), .out_dst_ip(out_dst_ip2),
    .out_protocol(out_protocol2), .out_total_len(out_total_len2), .out_valid(out_valid2),
    .out_ready(out_ready), .pkt_count(pkt_count2), .err_count(err_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds the word until the main instance accepts it, then returns #1 after that edge.
  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout observed=in_ready_low expected=accept_within_50");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr5(input logic [31:0] w0, input logic [31:0] w2,
                           input logic [31:0] src, input logic [31:0] dst);
    send_word(w0, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    send_word(w2, 1'b0);
    send_word(src, 1'b0);
    send_word(dst, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_src", out_src_ip, 32'd0);
    check("rst_dst", out_dst_ip, 32'd0);
    check("rst_pkt", {16'd0, pkt_count}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Good 5-word packet
    send_hdr5(32'h4500_0014, 32'h4011_0000, 32'hC0A8_0001, 32'h0A00_0001);
    idle(0);
    check("good_valid", {31'd0, out_valid}, 32'd1);
    check("good_src", out_src_ip, 32'hC0A8_0001);
    check("good_dst", out_dst_ip, 32'h0A00_0001);
    check("good_proto", {24'd0, out_protocol}, 32'h11);
    check("good_len", {16'd0, out_total_len}, 32'h0014);
    check("good_pkt", {16'd0, pkt_count}, 32'd1);
    idle(1);
    check("good_cleared", {31'd0, out_valid}, 32'd0);

    // Bad version, then a good packet
    send_hdr5(32'h6500_0014, 32'h4011_0000, 32'hC0A8_0002, 32'h0A00_0002);
    check("badver_no_valid", {31'd0, out_valid}, 32'd0);
    check("badver_err", {16'd0, err_count}, 32'd1);
    check("badver_pkt", {16'd0, pkt_count}, 32'd1);
    send_hdr5(32'h4500_0028, 32'h4006_0000, 32'h0A0A_0A0A, 32'h0B0B_0B0B);
    check("after_bad_valid", {31'd0, out_valid}, 32'd1);
    check("after_bad_src", out_src_ip, 32'h0A0A_0A0A);
    check("after_bad_dst", out_dst_ip, 32'h0B0B_0B0B);
    check("after_bad_proto", {24'd0, out_protocol}, 32'h06);
    check("after_bad_len", {16'd0, out_total_len}, 32'h0028);
    idle(1);

    // Truncated at index 3
    send_word(32'h4500_0014, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    send_word(32'h4011_0000, 1'b0);
    send_word(32'h0102_0304, 1'b1);
    idle(1);
    check("trunc_no_valid", {31'd0, out_valid}, 32'd0);
    check("trunc_err", {16'd0, err_count}, 32'd2);
    send_hdr5(32'h4500_0030, 32'h4001_0000, 32'h0505_0505, 32'h0606_0606);
    check("after_trunc_src", out_src_ip, 32'h0505_0505);
    check("after_trunc_pkt", {16'd0, pkt_count}, 32'd3);
    idle(1);

    // Backpressure: two back-to-back packets with the consumer stalled
    out_ready = 1'b0;
    send_hdr5(32'h4500_0014, 32'h4011_0000, 32'h1111_1111, 32'h2222_2222);
    check("bp_first_valid", {31'd0, out_valid}, 32'd1);
    send_word(32'h4500_0014, 1'b0);
    check("bp_w0_ready", {31'd0, in_ready}, 32'd1);
    send_word(32'h0000_0000, 1'b0);
    send_word(32'h4006_0000, 1'b0);
    send_word(32'h3333_3333, 1'b0);
    in_data  = 32'h4444_4444;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    check("bp_held_src", out_src_ip, 32'h1111_1111);
    check("bp_held_dst", out_dst_ip, 32'h2222_2222);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("bp_swap_valid", {31'd0, out_valid}, 32'd1);
    check("bp_swap_src", out_src_ip, 32'h3333_3333);
    check("bp_swap_dst", out_dst_ip, 32'h4444_4444);
    check("bp_swap_proto", {24'd0, out_protocol}, 32'h06);
    check("bp_pkt", {16'd0, pkt_count}, 32'd5);
    idle(2);
    check("bp_still_held", out_src_ip, 32'h3333_3333);
    out_ready = 1'b1;
    idle(1);
    check("bp_cleared", {31'd0, out_valid}, 32'd0);

    // IHL=6 with options and payload; skipped words look like headers
    send_word(32'h4600_0050, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    send_word(32'h4011_0000, 1'b0);
    send_word(32'hC0A8_000A, 1'b0);
    send_word(32'h0A00_000A, 1'b0);
    check("opt_src", out_src_ip, 32'hC0A8_000A);
    check("opt_dst", out_dst_ip, 32'h0A00_000A);
    check("opt_len", {16'd0, out_total_len}, 32'h0050);
    for (int i = 5; i < 20; i++) send_word(32'h4500_0014 + i, i == 19);
    check("opt_skip_pkt", {16'd0, pkt_count}, 32'd6);
    check("opt_skip_err", {16'd0, err_count}, 32'd2);
    send_hdr5(32'h4500_0018, 32'h4011_0000, 32'h0707_0707, 32'h0808_0808);
    check("opt_next_src", out_src_ip, 32'h0707_0707);
    check("opt_next_pkt", {16'd0, pkt_count}, 32'd7);

    // Valid header carrying in_last is truncated
    send_word(32'h4500_0014, 1'b1);
    check("w0_last_err", {16'd0, err_count}, 32'd3);
    idle(1);

    // Saturation on the 2-bit instance
    rst2 = 1'b0;
    for (int p = 0; p < 5; p++) begin
      send_word(32'h6500_0014, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b1);
    end
    idle(1);
    check("sat_err", {30'd0, err_count2}, 32'd3);
    check("sat_pkt", {30'd0, pkt_count2}, 32'd0);

    // Mid-packet reset with a result pending
    out_ready = 1'b0;
    send_hdr5(32'h4500_0014, 32'h4011_0000, 32'h0909_0909, 32'h0A0A_0A0A);
    send_word(32'h4500_0014, 1'b0);
    send_word(32'h0000_0000, 1'b0);
    in_valid = 1'b0;
    rst  = 1'b1;
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rst2 = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_src", out_src_ip, 32'd0);
    check("mid_rst_dst", out_dst_ip, 32'd0);
    check("mid_rst_proto", {24'd0, out_protocol}, 32'd0);
    check("mid_rst_len", {16'd0, out_total_len}, 32'd0);
    check("mid_rst_pkt", {16'd0, pkt_count}, 32'd0);
    check("mid_rst_err", {16'd0, err_count}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_sat_err", {30'd0, err_count2}, 32'd0);
    out_ready = 1'b1;
    send_hdr5(32'h4500_0020, 32'h4011_0000, 32'h0C0C_0C0C, 32'h0D0D_0D0D);
    check("post_rst_src", out_src_ip, 32'h0C0C_0C0C);
    check("post_rst_len", {16'd0, out_total_len}, 32'h0020);
    check("post_rst_pkt", {16'd0, pkt_count}, 32'd1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ipv4_header_extractor.md
# ipv4_header_extractor

Parses a word-aligned IPv4 packet stream and extracts the source and destination addresses, protocol and total length for each well-formed header. It sits directly upstream of `ipv4_packet_filter`: `out_src_ip`/`out_dst_ip` drive the filter's `src_ip`/`dst_ip`, held stable until the downstream consumer accepts them. Malformed or truncated headers are dropped and counted; no address pair is emitted for them.

## Interface
- `CNT_W`, 16: width of the saturating packet and error counters.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  32  packet word; big-endian, so header byte 0 is `[31:24]`.
- `in_valid`  in  1  `in_data`/`in_last` are valid.
- `in_last`  in  1  final word of the packet.
- `in_ready`  out  1  block accepts a word this cycle.
- `out_src_ip`  out  32  captured header word 3.
- `out_dst_ip`  out  32  captured header word 4.
- `out_protocol`  out  8  captured header word 2 `[23:16]`.
- `out_total_len`  out  16  captured header word 0 `[15:0]`.
- `out_valid`  out  1  extracted fields are valid.
- `out_ready`  in  1  downstream accepts the extracted fields.
- `pkt_count`  out  CNT_W  good headers emitted; saturating.
- `err_count`  out  CNT_W  dropped packets; saturating.

## Operation
- A word is accepted when `in_valid && in_ready`. Word index counts from 0 at the start of each packet.
- **State W0** (expect word 0):
  - On accept, check version `[31:28]==4` and IHL `[27:24]>=5`.
  - Pass: latch total length; go to HDR with index 1.
  - Fail: `err_count++`, then go to SKIP. If `in_last` is set on this word, go to W0 instead.
  - A pass with `in_last` set is a truncated packet: `err_count++`, stay in W0.
- **State HDR** (indices 1 to 4):
  - Index 2: latch protocol.
  - Index 3: latch src.
  - Index 4: latch dst; set `out_valid`; `pkt_count++`. Go to W0 if `in_last`, otherwise go to SKIP.
  - `in_last` on index 1, 2 or 3: truncated packet. `err_count++`, go to W0, `out_valid` is not set.
- **State SKIP**: consume options and payload words without inspecting them. Go to W0 on the accepted word with `in_last`.
- **Backpressure**:
  - `in_ready = !(out_valid && state==HDR && index==4 && !out_ready)`.
  - Payload and the start of the next header keep flowing while a result is pending. Only the dst-capture word stalls.
- **Output register**:
  - `out_valid` clears on `out_valid && out_ready`.
  - If a clear and a new capture happen in the same cycle, `out_valid` stays 1 and the fields take the new values.
  - Output fields change only on capture.
- Counters saturate at `2^CNT_W-1` and never wrap.

## Timing
- Reset values:
  - `out_valid=0`; all `out_*` fields 0.
  - `pkt_count=0`, `err_count=0`.
  - State is W0 with index 0.
  - `in_ready=1` in the first cycle after reset.
- Latency: `out_valid` rises in the cycle after word 4 is accepted. The counters update in that same edge.
- Fields are stable for every cycle in which `out_valid=1`.
- `ipv4_packet_filter` registers its match, so its `block_packet` for a pair is valid one cycle after that pair is presented. The consumer must not assert `out_ready` before sampling `block_packet`.
- Reset asserted mid-packet:
  - The partial packet is discarded and any pending result is lost.
  - After reset the next accepted word is treated as word 0. The upstream source is responsible for restarting at a packet boundary.
- `in_valid=0` bubbles are allowed anywhere; state and index hold across them.
- Throughput is one word per cycle when `out_ready=1`.

## Test plan
- **Good 5-word packet, `out_ready=1`.**
  - Stimulus: `45000014`, `00000000`, `40110000`, `C0A80001`, `0A000001` (last on the 5th word).
  - Expected: one cycle later `out_valid=1`, `src=C0A80001`, `dst=0A000001`, `protocol=11`, `total_len=0014`, `pkt_count=1`.
- **Bad version.**
  - Stimulus: word 0 = `65000014`, 5-word packet.
  - Expected: no `out_valid`; `err_count=1`; the next good packet extracts normally.
- **Truncated packet.**
  - Stimulus: 4-word packet with `in_last` on index 3.
  - Expected: no `out_valid`; `err_count=1`; state returns to W0.
- **Backpressure.**
  - Stimulus: two back-to-back 5-word packets, `out_ready=0`.
  - Expected: the first result is held; `in_ready=0` only on the second packet's word 4. Raising `out_ready` for one cycle then shows the second packet's addresses, with `pkt_count=2`.
- **Options and payload.**
  - Stimulus: IHL=6 packet of 20 words.
  - Expected: addresses are taken from words 3 and 4; words 5 to 19 are skipped; the next packet parses correctly.
- **Saturation and reset.**
  - Stimulus: `CNT_W=2` with 5 bad packets, then `rst` asserted mid-packet.
  - Expected: `err_count` stays at 3; after `rst` all outputs are 0 and `in_ready=1`.
